// File: rtl/matmul_pkg.sv
// Shared types and constants for the matmul host-side stream initiator.
// Element width/count defaults and the host FSM state encoding.
package matmul_pkg;

   localparam int MM_WIDTH = 16;
   localparam int MM_ELEMS = 16;

   typedef logic [MM_WIDTH-1:0] elem_t;

   typedef enum logic [1:0] {LOAD, START, WAIT, DRAIN} mm_host_state_t;

   // A frame is well formed only when s_last coincides with the final element slot.
   function automatic logic frame_error(input logic last, input logic [4:0] cnt,
                                        input logic [4:0] cnt_last);
      return last != (cnt == cnt_last);
   endfunction

endpackage

// File: rtl/mm_flat_serializer.sv
// Latches the accelerator's packed C result and streams it out element by element
// over a valid/ready interface; reports the final accepted beat to the parent.
module mm_flat_serializer
   import matmul_pkg::*;
#(
   parameter int WIDTH       = MM_WIDTH,
   parameter int MATRIX_SIZE = MM_ELEMS
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         load_i,
   input  logic [WIDTH*MATRIX_SIZE-1:0] c_flat_i,
   input  logic                         m_ready,
   output logic                         m_valid,
   output logic [WIDTH-1:0]             m_data,
   output logic                         m_last,
   output logic                         done_o
);

   localparam int IDX_W = $clog2(MATRIX_SIZE);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MATRIX_SIZE - 1);

   logic [WIDTH*MATRIX_SIZE-1:0] c_q, c_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic                         vld_q, vld_d;
   logic                         beat;

   assign beat = vld_q && m_ready;

   always_comb begin
      c_d   = c_q;
      idx_d = idx_q;
      vld_d = vld_q;
      if (load_i) begin
         c_d   = c_flat_i;
         idx_d = '0;
         vld_d = 1'b1;
      end else if (beat) begin
         if (idx_q == IDX_LAST) begin
            vld_d = 1'b0;
            idx_d = '0;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
   end

   // Output stage: data is a pure mux of the latch, so it holds during backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         c_q   <= '0;
         idx_q <= '0;
         vld_q <= 1'b0;
      end else begin
         c_q   <= c_d;
         idx_q <= idx_d;
         vld_q <= vld_d;
      end
   end

   assign m_valid = vld_q;
   assign m_data  = vld_q ? c_q[int'(idx_q)*WIDTH +: WIDTH] : '0;
   assign m_last  = vld_q && (idx_q == IDX_LAST);
   assign done_o  = beat && (idx_q == IDX_LAST);

endmodule

// File: rtl/matmul_stream_host.sv
// Host initiator for the 4x4 matmul accelerator: packs an A/B element stream into
// flat operand buses, pulses start, waits for done (with timeout) and streams C back.
module matmul_stream_host
   import matmul_pkg::*;
#(
   parameter int WIDTH       = MM_WIDTH,
   parameter int MATRIX_SIZE = MM_ELEMS,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [WIDTH-1:0]             s_data,
   input  logic                         s_last,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [WIDTH-1:0]             m_data,
   output logic                         m_last,
   output logic                         acc_start,
   output logic [WIDTH*MATRIX_SIZE-1:0] acc_A_flat,
   output logic [WIDTH*MATRIX_SIZE-1:0] acc_B_flat,
   input  logic [WIDTH*MATRIX_SIZE-1:0] acc_C_flat,
   input  logic                         acc_done,
   output logic                         busy,
   output logic                         err_frame,
   output logic                         err_timeout
);

   localparam int TMR_W = $clog2(TIMEOUT_CYC);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [4:0]       CNT_LAST = 5'(2 * MATRIX_SIZE - 1);

   mm_host_state_t               state_q, state_d;
   logic [4:0]                   cnt_q, cnt_d;
   logic [TMR_W-1:0]             timer_q, timer_d;
   logic [WIDTH*MATRIX_SIZE-1:0] a_q, a_d;
   logic [WIDTH*MATRIX_SIZE-1:0] b_q, b_d;
   logic                         beat;
   logic                         capture;
   logic                         drain_done;

   assign beat = s_valid && s_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      timer_d     = timer_q;
      a_d         = a_q;
      b_d         = b_q;
      capture     = 1'b0;
      err_frame   = 1'b0;
      err_timeout = 1'b0;
      case (state_q)
         LOAD: begin
            if (beat) begin
               if (int'(cnt_q) < MATRIX_SIZE) begin
                  a_d[int'(cnt_q)*WIDTH +: WIDTH] = s_data;
               end else begin
                  b_d[(int'(cnt_q) - MATRIX_SIZE)*WIDTH +: WIDTH] = s_data;
               end
               // Partial operands from an aborted frame stay on the buses.
               if (frame_error(s_last, cnt_q, CNT_LAST)) begin
                  err_frame = 1'b1;
                  cnt_d     = '0;
               end else if (s_last) begin
                  state_d = START;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end
         START: begin
            timer_d = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (acc_done) begin
               capture = 1'b1;
               state_d = DRAIN;
            end else if (timer_q == TMR_LAST) begin
               err_timeout = 1'b1;
               state_d     = LOAD;
               cnt_d       = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         DRAIN: begin
            if (drain_done) begin
               state_d = LOAD;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = LOAD;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= LOAD;
         cnt_q   <= '0;
         timer_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         timer_q <= timer_d;
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end

   assign s_ready    = (state_q == LOAD);
   assign acc_start  = (state_q == START);
   assign busy       = !((state_q == LOAD) && (cnt_q == '0));
   assign acc_A_flat = a_q;
   assign acc_B_flat = b_q;

   mm_flat_serializer #(
      .WIDTH       (WIDTH),
      .MATRIX_SIZE (MATRIX_SIZE)
   ) u_ser (
      .clk      (clk),
      .rst      (rst),
      .load_i   (capture),
      .c_flat_i (acc_C_flat),
      .m_ready  (m_ready),
      .m_valid  (m_valid),
      .m_data   (m_data),
      .m_last   (m_last),
      .done_o   (drain_done)
   );

endmodule

// File: tb/tb_matmul_stream_host.sv
// Bench for matmul_stream_host: behavioural accelerator, frame-level reference model
// with per-cycle compare, plus literal result checks for hand-computed frames.
module tb_matmul_stream_host;

   localparam int W  = 16;
   localparam int N  = 16;
   localparam int TO = 16;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           s_valid = 1'b0;
   logic           s_ready;
   logic [W-1:0]   s_data = '0;
   logic           s_last = 1'b0;
   logic           m_valid;
   logic           m_ready = 1'b1;
   logic [W-1:0]   m_data;
   logic           m_last;
   logic           acc_start;
   logic [W*N-1:0] acc_A_flat, acc_B_flat;
   logic [W*N-1:0] acc_C_flat = '0;
   logic           acc_done;
   logic           acc_done_m = 1'b0;
   logic           stray_done = 1'b0;
   logic           busy, err_frame, err_timeout;

   assign acc_done = acc_done_m | stray_done;

   matmul_stream_host #(.WIDTH(W), .MATRIX_SIZE(N), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .acc_start(acc_start), .acc_A_flat(acc_A_flat), .acc_B_flat(acc_B_flat),
      .acc_C_flat(acc_C_flat), .acc_done(acc_done),
      .busy(busy), .err_frame(err_frame), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural accelerator ----------------
   bit acc_en = 1'b1;
   initial begin
      forever begin
         @(negedge clk);
         if (acc_start && acc_en && !rst) begin
            repeat ($urandom_range(1, 8)) @(posedge clk);
            #1;
            for (int r = 0; r < 4; r++)
               for (int c = 0; c < 4; c++) begin
                  int unsigned s;
                  s = 0;
                  for (int k = 0; k < 4; k++)
                     s += acc_A_flat[(4*r+k)*W +: W] * acc_B_flat[(4*k+c)*W +: W];
                  acc_C_flat[(4*r+c)*W +: W] = s[W-1:0];
               end
            acc_done_m = 1'b1;
            @(posedge clk);
            #1 acc_done_m = 1'b0;
         end
      end
   end

   // ---------------- m_ready driver ----------------
   int mr_mode = 0;  // 0: always 1, 1: toggle, 2: random, 3: held by stimulus
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (mr_mode)
            0: m_ready = 1'b1;
            1: m_ready = ~m_ready;
            2: m_ready = 1'($urandom_range(0, 1));
            default: ;
         endcase
      end
   end

   // ---------------- frame-level reference model + compare ----------------
   int            mphase = 0;   // 0 load, 1 start, 2 wait, 3 drain
   int            mcnt = 0;
   int            wait_n = 0;
   logic [W-1:0]  mA[N], mB[N];
   logic [W-1:0]  expq[$];
   logic [W-1:0]  rx[$];
   bit            mon_en = 1'b0;
   int            n_start = 0, n_errf = 0, n_errt = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         chk("s_ready", s_ready, mphase == 0);
         chk("busy", busy, !(mphase == 0 && mcnt == 0));
         chk("acc_start", acc_start, mphase == 1);
         chk("m_valid", m_valid, mphase == 3);
         chk("err_frame", err_frame,
             mphase == 0 && s_valid && (s_last != (mcnt == 2*N-1)));
         chk("err_timeout", err_timeout, mphase == 2 && !acc_done && wait_n == TO-1);
         if (mphase == 3 && expq.size() > 0) begin
            chk("m_data", m_data, expq[0]);
            chk("m_last", m_last, expq.size() == 1);
         end
         if (acc_start) n_start++;
         if (err_frame) n_errf++;
         if (err_timeout) n_errt++;
         if (m_valid && m_ready && !rst) rx.push_back(m_data);
      end
      if (rst) begin
         mphase = 0; mcnt = 0; wait_n = 0; expq.delete();
      end else begin
         case (mphase)
            0: if (s_valid) begin
                  if (mcnt < N) mA[mcnt] = s_data; else mB[mcnt-N] = s_data;
                  if (s_last && mcnt == 2*N-1) begin
                     for (int r = 0; r < 4; r++)
                        for (int c = 0; c < 4; c++) begin
                           int unsigned s;
                           s = 0;
                           for (int k = 0; k < 4; k++) s += mA[4*r+k] * mB[4*k+c];
                           expq.push_back(s[W-1:0]);
                        end
                     mphase = 1; mcnt = 0;
                  end else if (s_last || mcnt == 2*N-1) mcnt = 0;
                  else mcnt++;
               end
            1: begin mphase = 2; wait_n = 0; end
            2: if (acc_done) mphase = 3;
               else if (wait_n == TO-1) begin mphase = 0; mcnt = 0; expq.delete(); end
               else wait_n++;
            default: if (m_ready) begin
                  void'(expq.pop_front());
                  if (expq.size() == 0) mphase = 0;
               end
         endcase
      end
   end

   // ---------------- stimulus ----------------
   logic [W-1:0] fr[2*N];

   task automatic send_beat(input logic [W-1:0] d, input logic l);
      int g = 0;
      s_valid = 1'b1; s_data = d; s_last = l;
      do begin @(negedge clk); g++; end while (!s_ready && g < 300);
      if (!s_ready) chk("s_ready_wait", 0, 1);
      @(posedge clk);
      #1 s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic send_frame(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         send_beat(fr[i], i == n-1);
         repeat ((gap < 0) ? $urandom_range(0, 2) : gap) begin @(posedge clk); #1; end
      end
   endtask

   task automatic wait_idle(input string nm);
      int g = 0;
      while (mphase != 0 && g < 500) begin @(negedge clk); g++; end
      if (mphase != 0) chk(nm, 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic check_rx(input string nm, input logic [W-1:0] e[N]);
      chk({nm, "_count"}, rx.size(), N);
      for (int i = 0; i < N && i < rx.size(); i++) chk(nm, rx[i], e[i]);
   endtask

   logic [W-1:0] exp1[N];
   logic [W-1:0] exp24[N];

   initial begin
      for (int i = 0; i < N; i++) begin exp1[i] = W'(i + 1); exp24[i] = W'(24); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_s_ready", s_ready, 1);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_acc_start", acc_start, 0);
      chk("rst_A_flat_zero", acc_A_flat == '0, 1);
      chk("rst_B_flat_zero", acc_B_flat == '0, 1);
      chk("rst_busy", busy, 0);
      chk("rst_errs", {err_frame, err_timeout}, 0);
      @(posedge clk); #1 rst = 1'b0;
      mon_en = 1'b1;

      // 1: identity x 1..16, contiguous
      for (int i = 0; i < N; i++) begin
         fr[i] = (i % 5 == 0) ? W'(1) : W'(0);
         fr[N+i] = W'(i + 1);
      end
      rx.delete();
      send_frame(2*N, 0);
      wait_idle("t1_idle");
      check_rx("t1_c", exp1);
      chk("t1_starts", n_start, 1);

      // 2: same frame, sparse input and toggling m_ready
      rx.delete();
      mr_mode = 1;
      send_frame(2*N, 2);
      wait_idle("t2_idle");
      check_rx("t2_c", exp1);
      mr_mode = 0;

      // 3: short frame then A=2, B=3
      for (int i = 0; i < 6; i++) fr[i] = W'($urandom);
      send_frame(6, 0);
      chk("t3_errf", n_errf, 1);
      chk("t3_no_start", n_start, 2);
      for (int i = 0; i < N; i++) begin fr[i] = W'(2); fr[N+i] = W'(3); end
      rx.delete();
      send_frame(2*N, 0);
      wait_idle("t3_idle");
      check_rx("t3_c", exp24);

      // 4: no done -> timeout
      acc_en = 1'b0;
      rx.delete();
      for (int i = 0; i < 2*N; i++) fr[i] = W'($urandom);
      send_frame(2*N, 0);
      wait_idle("t4_idle");
      chk("t4_errt", n_errt, 1);
      chk("t4_no_output", rx.size(), 0);
      acc_en = 1'b1;

      // 5: reset in the middle of drain
      rx.delete();
      for (int i = 0; i < 2*N; i++) fr[i] = W'($urandom);
      send_frame(2*N, 0);
      begin
         int g = 0;
         while (rx.size() < 7 && g < 300) begin @(negedge clk); g++; end
         chk("t5_reach_idx7", rx.size(), 7);
      end
      @(posedge clk);
      #1 rst = 1'b1; mr_mode = 3; m_ready = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("t5_m_valid", m_valid, 0);
      chk("t5_s_ready", s_ready, 1);
      chk("t5_busy", busy, 0);
      mr_mode = 0;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin fr[i] = W'(2); fr[N+i] = W'(3); end
      rx.delete();
      send_frame(2*N, 0);
      wait_idle("t5_idle");
      check_rx("t5_c", exp24);

      // 6: stray done while loading
      stray_done = 1'b1;
      @(posedge clk); #1 stray_done = 1'b0;
      @(negedge clk);
      chk("t6_m_valid", m_valid, 0);
      chk("t6_s_ready", s_ready, 1);

      // random frames with random gaps and backpressure
      mr_mode = 2;
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < 2*N; i++) fr[i] = W'($urandom);
         send_frame(2*N, -1);
         wait_idle("rand_idle");
      end
      mr_mode = 0;
      repeat (4) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
